// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters a burst of writes into a shared FIFO port.
// Writes are zero-latency: the FIFO and the owning requester both consume the word on the same edge.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE_LIMIT  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     owner, owner_next;
  logic [IDX_W-1:0]     last_owner, last_owner_next;
  logic [CNT_W-1:0]     count, count_next;
  logic [CNT_W-1:0]     limit, limit_next;
  logic [NUM_REQ-1:0]   grant_next;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand_idx;
  int unsigned          cand;
  logic                 owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign busy       = (state == BURST);
  assign owner_req  = req[owner];
  assign owner_data = words[owner];

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_owner) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    fifo_write      = busy & owner_req & ~fifo_full & clk_enable;
    ack             = fifo_write ? grant : '0;
    fifo_write_data = busy ? owner_data : '0;
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    count_next      = count;
    limit_next      = limit;
    grant_next      = grant;
    case (state)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          state_next           = BURST;
          owner_next           = pick_idx;
          count_next           = '0;
          limit_next           = fifo_almost_full ? ONE_LIMIT : FULL_LIMIT;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
        end
      end
      BURST: begin
        if (fifo_write) begin
          count_next = count + 1'b1;
        end
        // A full FIFO only stalls; the burst ends on the limit or when the owner withdraws.
        if (!owner_req || (fifo_write && (count_next == limit))) begin
          state_next      = IDLE;
          last_owner_next = owner;
          count_next      = '0;
          grant_next      = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;
      count      <= '0;
      limit      <= FULL_LIMIT;
      grant      <= '0;
    end else if (clk_enable) begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      count      <= count_next;
      limit      <= limit_next;
      grant      <= grant_next;
    end
  end

endmodule
